ps2_key_sequencer: RTL
======================

# ps2_key_sequencer

Sequencer between the PS/2 keyboard interface controller and the user-visible key logic. It parses the raw received byte stream into complete make/break key events, handling the 0xF0 break prefix and the 0xE0 extended prefix. It also runs the host-to-keyboard "Set LEDs" command sequence (0xED, mask) with ACK checking, resend retry and timeout. It owns the controller's command port, and no other block drives it.

## Interface
- ACK_TIMEOUT, default 2_500_000: cycles to wait for an ACK byte after a command byte is sent (50 ms at 50 MHz).
- MAX_RETRY, default 3: resends allowed per command byte on 0xFE before error.
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the CLOCK_50 rising edge.
- received_data  in  8  byte from the PS/2 controller.
- received_data_en  in  1  one-cycle strobe; received_data is valid this cycle.
- command_was_sent  in  1  one-cycle strobe from the controller: the command byte finished transmission.
- error_communication_timed_out  in  1  one-cycle strobe from the controller: the transmit attempt failed.
- led_req  in  1  one-cycle request to send led_mask; ignored while led_busy=1.
- led_mask  in  3  {caps, num, scroll}; sampled on the led_req cycle.
- the_command  out  8  byte to transmit.
- send_command  out  1  command request to the controller.
- key_valid  out  1  one-cycle strobe; a complete key event is available.
- key_code  out  8  final scan code of the event; held until the next event.
- key_extended  out  1  event was 0xE0-prefixed; held with key_code.
- key_released  out  1  event was a break; held with key_code.
- led_busy  out  1  LED command sequence in progress.
- led_error  out  1  sticky; set on abort, cleared by the next accepted led_req or by reset.

## Operation
- Decoder FSM states: D_IDLE, D_E0, D_F0, D_E0F0. Transitions occur only when a byte is routed to the decoder:
  - D_IDLE: 0xE0 goes to D_E0; 0xF0 goes to D_F0; any other code emits a make event (ext=0).
  - D_E0: 0xF0 goes to D_E0F0; 0xE0 stays in D_E0; any other code emits a make event (ext=1).
  - D_F0: 0xE0 or 0xF0 is a protocol error; return to D_IDLE with no event. Any other code emits a break event (ext=0).
  - D_E0F0: 0xE0 or 0xF0 returns to D_IDLE with no event. Any other code emits a break event (ext=1).
  - Every emit returns to D_IDLE.
- Bytes 0xFA, 0xFE, 0xAA, 0xEE, 0x00 and 0xFF are never keys. In D_IDLE they are discarded. In any other state they reset the decoder to D_IDLE with no event.
- Command FSM states: C_IDLE, C_SEND1, C_ACK1, C_SEND2, C_ACK2.
  - C_IDLE: led_req latches the mask, clears led_error and the retry count, then moves to C_SEND1 (the_command=0xED).
  - C_SENDn: assert send_command. command_was_sent moves to C_ACKn, loads the timeout counter with ACK_TIMEOUT and drops send_command. error_communication_timed_out aborts.
  - C_ACKn: 0xFA advances. From C_ACK1, go to C_SEND2 with the_command={5'b0,mask} and the retry count cleared. From C_ACK2, go to C_IDLE.
  - C_ACKn: 0xFE returns to C_SENDn with the same byte and increments the retry count. If the count already equals MAX_RETRY, abort instead.
  - C_ACKn: any other byte is routed to the decoder and the state is unchanged. If the counter reaches 0, abort.
- Abort: set led_error, go to C_IDLE, drop send_command.
- Byte routing: while the command FSM is in C_ACK1 or C_ACK2, 0xFA and 0xFE go to the command FSM only. At all other times every byte goes to the decoder.
- led_busy = (command state != C_IDLE).

## Timing
- Reset values: the_command=0x00, send_command=0, key_valid=0, key_code=0x00, key_extended=0, key_released=0, led_busy=0, led_error=0. Decoder state is D_IDLE and command state is C_IDLE.
- reset_n low mid-sequence returns both FSMs to idle on the next edge. Any partial prefix or command sequence is discarded.
- Key event latency: key_valid, key_code and the flags update on the edge after the received_data_en cycle carrying the final byte (1 cycle). key_valid is high for exactly 1 cycle.
- send_command: registered. It rises 1 cycle after entry to C_SENDn and stays high until the cycle after command_was_sent or the error strobe. the_command is stable during the whole interval.
- led_req accepted at edge N gives led_busy=1 from N+1. led_busy falls on the edge after the 0xFA of C_ACK2 is received.
- Timeout counter: 22-bit down-counter, decremented each cycle in C_ACKn. It expires after exactly ACK_TIMEOUT cycles with no ACK.
- led_req arriving on the same cycle as the final ACK is ignored, because led_busy is still 1.
- A key byte arriving during C_ACKn is decoded normally with the usual 1-cycle latency.

## Test plan
- Byte 0x1C: key_valid for 1 cycle with key_code=0x1C, ext=0, rel=0. Sequence F0,1C: one event with code=0x1C, rel=1, and no event on F0.
- Sequence E0,75 gives code=0x75, ext=1, rel=0. Sequence E0,F0,75 gives ext=1, rel=1. Sequence F0,E0,1C gives a single make event for 0x1C (ext=0).
- led_req with mask=3'b101, and the model answers FA to each byte: the_command=0xED then 0x05, send_command handshakes correct. led_busy falls after the second FA; led_error=0; no key events are emitted.
- Model answers FE to 0xED four times with MAX_RETRY=3: 0xED is sent four times in total, then led_error=1 and led_busy=0.
- No ACK after 0xED (ACK_TIMEOUT reduced to 100 in the bench): abort at exactly 100 cycles after command_was_sent, with led_error=1.
- Sequence E0,F0 then reset_n=0 for 1 cycle, then byte 0x1C: make event for 0x1C with ext=0, rel=0. All outputs are at reset values during reset.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_sequencer
// Purpose  : Sits between a PS/2 interface controller and user key logic.
//            - Decodes the received byte stream into make/break key events,
//              understanding the 0xE0 (extended) and 0xF0 (break) prefixes.
//            - Runs the host-to-keyboard "Set LEDs" sequence (0xED, mask),
//              checking each byte for ACK (0xFA), resending on 0xFE up to
//              MAX_RETRY times and aborting after ACK_TIMEOUT cycles.
// Ports    : CLOCK_50, reset_n (sync, active-low)
//            received_data/_en      : byte stream from the controller
//            command_was_sent       : controller finished sending the_command
//            error_communication_timed_out : controller transmit failure
//            led_req/led_mask       : request to program {caps,num,scroll}
//            the_command/send_command : command port to the controller
//            key_valid/key_code/key_extended/key_released : key events
//            led_busy/led_error     : LED sequence status
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_sequencer #(
    parameter int ACK_TIMEOUT = 2_500_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    input  logic       led_req,
    input  logic [2:0] led_mask,
    output logic [7:0] the_command,
    output logic       send_command,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_released,
    output logic       led_busy,
    output logic       led_error
);

    localparam logic [21:0] C_TIMEOUT   = 22'(ACK_TIMEOUT);
    localparam logic [3:0]  C_MAX_RETRY = 4'(MAX_RETRY);

    localparam logic [7:0] C_B_E0 = 8'hE0;
    localparam logic [7:0] C_B_F0 = 8'hF0;
    localparam logic [7:0] C_B_ED = 8'hED;
    localparam logic [7:0] C_B_FA = 8'hFA;
    localparam logic [7:0] C_B_FE = 8'hFE;

    // Decoder states
    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_E0   = 2'd1;
    localparam logic [1:0] D_F0   = 2'd2;
    localparam logic [1:0] D_E0F0 = 2'd3;

    // Command states
    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_SEND1 = 3'd1;
    localparam logic [2:0] C_ACK1  = 3'd2;
    localparam logic [2:0] C_SEND2 = 3'd3;
    localparam logic [2:0] C_ACK2  = 3'd4;

    logic [1:0]  dec_state_q, dec_state_d;
    logic [2:0]  cmd_state_q, cmd_state_d;
    logic [7:0]  the_command_q, the_command_d;
    logic        send_command_q, send_command_d;
    logic        key_valid_q;
    logic [7:0]  key_code_q;
    logic        key_extended_q, key_released_q;
    logic        led_error_q;
    logic [2:0]  mask_q;
    logic [3:0]  retry_q;
    logic [21:0] timer_q;

    logic w_in_ack, w_in_send, w_cmd_byte, w_dec_byte, w_non_key;
    logic w_is_e0, w_is_f0;
    logic w_emit, w_emit_ext, w_emit_rel;
    logic w_accept, w_abort, w_ack_ok, w_resend, w_sent;

    // ------------------------------------------------------------------
    // Byte routing: ACK/RESEND bytes belong to the command FSM only while
    // it is waiting for a response; everything else feeds the decoder.
    // ------------------------------------------------------------------
    assign w_in_ack   = (cmd_state_q == C_ACK1) || (cmd_state_q == C_ACK2);
    assign w_in_send  = (cmd_state_q == C_SEND1) || (cmd_state_q == C_SEND2);
    assign w_cmd_byte = received_data_en && w_in_ack &&
                        ((received_data == C_B_FA) || (received_data == C_B_FE));
    assign w_dec_byte = received_data_en && !w_cmd_byte;

    assign w_is_e0   = (received_data == C_B_E0);
    assign w_is_f0   = (received_data == C_B_F0);
    assign w_non_key = (received_data == 8'hFA) || (received_data == 8'hFE) ||
                       (received_data == 8'hAA) || (received_data == 8'hEE) ||
                       (received_data == 8'h00) || (received_data == 8'hFF);

    // ------------------------------------------------------------------
    // Decoder FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            dec_state_q <= D_IDLE;
        end else begin
            dec_state_q <= dec_state_d;
        end
    end

    always_comb begin
        dec_state_d = dec_state_q;
        if (w_dec_byte) begin
            if (w_non_key) begin
                dec_state_d = D_IDLE;
            end else begin
                case (dec_state_q)
                    D_IDLE: begin
                        if (w_is_e0)      dec_state_d = D_E0;
                        else if (w_is_f0) dec_state_d = D_F0;
                    end
                    D_E0: begin
                        if (w_is_f0)      dec_state_d = D_E0F0;
                        else if (!w_is_e0) dec_state_d = D_IDLE;
                    end
                    default: dec_state_d = D_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_emit     = 1'b0;
        w_emit_ext = 1'b0;
        w_emit_rel = 1'b0;
        if (w_dec_byte && !w_non_key && !w_is_e0 && !w_is_f0) begin
            w_emit     = 1'b1;
            w_emit_ext = (dec_state_q == D_E0) || (dec_state_q == D_E0F0);
            w_emit_rel = (dec_state_q == D_F0) || (dec_state_q == D_E0F0);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            key_valid_q    <= 1'b0;
            key_code_q     <= 8'h00;
            key_extended_q <= 1'b0;
            key_released_q <= 1'b0;
        end else begin
            key_valid_q <= w_emit;
            if (w_emit) begin
                key_code_q     <= received_data;
                key_extended_q <= w_emit_ext;
                key_released_q <= w_emit_rel;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            cmd_state_q <= C_IDLE;
        end else begin
            cmd_state_q <= cmd_state_d;
        end
    end

    always_comb begin
        cmd_state_d = cmd_state_q;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_ack_ok    = 1'b0;
        w_resend    = 1'b0;
        w_sent      = 1'b0;
        case (cmd_state_q)
            C_IDLE: begin
                if (led_req) begin
                    w_accept    = 1'b1;
                    cmd_state_d = C_SEND1;
                end
            end
            C_SEND1, C_SEND2: begin
                if (error_communication_timed_out) begin
                    w_abort     = 1'b1;
                    cmd_state_d = C_IDLE;
                end else if (command_was_sent) begin
                    w_sent      = 1'b1;
                    cmd_state_d = (cmd_state_q == C_SEND1) ? C_ACK1 : C_ACK2;
                end
            end
            C_ACK1, C_ACK2: begin
                if (w_cmd_byte && (received_data == C_B_FA)) begin
                    w_ack_ok    = 1'b1;
                    cmd_state_d = (cmd_state_q == C_ACK1) ? C_SEND2 : C_IDLE;
                end else if (w_cmd_byte) begin
                    if (retry_q == C_MAX_RETRY) begin
                        w_abort     = 1'b1;
                        cmd_state_d = C_IDLE;
                    end else begin
                        w_resend    = 1'b1;
                        cmd_state_d = (cmd_state_q == C_ACK1) ? C_SEND1 : C_SEND2;
                    end
                end else if (timer_q <= 22'd1) begin
                    // Counter reaches zero on this edge: ACK_TIMEOUT
                    // cycles have elapsed since command_was_sent.
                    w_abort     = 1'b1;
                    cmd_state_d = C_IDLE;
                end
            end
            default: cmd_state_d = C_IDLE;
        endcase
    end

    always_comb begin
        // Drop the request on the same edge the controller reports an
        // outcome, so it is never seen high in an ACK or IDLE state.
        send_command_d = w_in_send && !command_was_sent && !error_communication_timed_out;
        the_command_d  = the_command_q;
        if (w_accept) begin
            the_command_d = C_B_ED;
        end else if (w_ack_ok && (cmd_state_q == C_ACK1)) begin
            the_command_d = {5'b0, mask_q};
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            send_command_q <= 1'b0;
            the_command_q  <= 8'h00;
            led_error_q    <= 1'b0;
            mask_q         <= 3'b000;
            retry_q        <= 4'd0;
            timer_q        <= 22'd0;
        end else begin
            send_command_q <= send_command_d;
            the_command_q  <= the_command_d;
            if (w_accept) begin
                mask_q      <= led_mask;
                led_error_q <= 1'b0;
            end else if (w_abort) begin
                led_error_q <= 1'b1;
            end
            if (w_accept || w_ack_ok) begin
                retry_q <= 4'd0;
            end else if (w_resend) begin
                retry_q <= retry_q + 4'd1;
            end
            if (w_sent) begin
                timer_q <= C_TIMEOUT;
            end else if (w_in_ack) begin
                timer_q <= timer_q - 22'd1;
            end
        end
    end

    assign the_command  = the_command_q;
    assign send_command = send_command_q;
    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign key_extended = key_extended_q;
    assign key_released = key_released_q;
    assign led_busy     = (cmd_state_q != C_IDLE);
    assign led_error    = led_error_q;

endmodule
`default_nettype wire
